// File: rtl/dmem_bus_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bus_pkg
//   Shared definitions for the data-memory / memory-mapped I/O bus arbiter:
//   default bus geometry, I/O register byte addresses, the port-1 lock state
//   encoding and the address-decode select encoding.
// -----------------------------------------------------------------------------
package dmem_bus_pkg;

  // Default bus geometry
  localparam int DBITS_DEF      = 32;
  localparam int DMEM_WBITS_DEF = 11;   // 2048 data-memory words
  localparam int MAX_LOCK_DEF   = 64;   // longest burst port 1 may hold the bus

  // Memory-mapped I/O byte addresses (bits [1:0] are not decoded)
  localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;  // 16-bit R/W
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;  // 10-bit R/W
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;  //  8-bit R/W
  localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;  //  4-bit RO
  localparam logic [31:0] ADDR_SW   = 32'hF000_0014;  // 10-bit RO

  // Port-1 bus lock
  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    COOLDOWN   // one cycle after a forced release: port 0 has strict priority
  } lock_state_e;

  // Target selected by the granted address
  typedef enum logic [2:0] {
    SEL_MEM,
    SEL_HEX,
    SEL_LEDR,
    SEL_LEDG,
    SEL_KEY,
    SEL_SW,
    SEL_NONE   // unmapped
  } sel_e;

endpackage

// File: rtl/io_sync2.sv
// -----------------------------------------------------------------------------
// io_sync2
//   Two-flop synchroniser for asynchronous input pins (KEY/SW). Each bit is
//   synchronised independently; the output lags the pin by two clock edges.
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, flops clear to 0
//   d_i    in   WIDTH raw asynchronous inputs
//   q_o    out  WIDTH synchronised outputs
// -----------------------------------------------------------------------------
module io_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so both flops sample the
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dmem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_bus_arbiter
//   Shares the single-ported data memory and the memory-mapped I/O registers
//   between port 0 (processor load/store) and port 1 (debug/loader). One
//   access is accepted per cycle, round-robin between the ports; port 1 may
//   lock the bus for bursts of at most MAX_LOCK cycles. Owns the HEX/LEDR/LEDG
//   output registers and the KEY/SW synchronisers. Every read returns data
//   exactly one cycle after its grant.
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   m0_*/m1_* req,we,addr,wdata   master requests (held until granted)
//   m1_lock                 port 1 requests exclusive ownership
//   m0_gnt, m1_gnt          access accepted this cycle (combinational)
//   m0_rvalid, m1_rvalid    read data valid, one cycle after a read grant
//   rdata                   shared read data, zero when no rvalid
//   mem_en/we/addr/wdata    data-memory request (grant cycle)
//   mem_rdata               data-memory read data, one cycle after mem_en
//   key_in, sw_in           raw KEY/SW pins
//   hex_out, ledr_out, ledg_out   I/O output registers
//   bus_err                 sticky flag: an unmapped address was accessed
// -----------------------------------------------------------------------------
module dmem_bus_arbiter
  import dmem_bus_pkg::*;
#(
  parameter int DBITS      = DBITS_DEF,
  parameter int DMEM_WBITS = DMEM_WBITS_DEF,
  parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DBITS-1:0]      m0_addr,
  input  logic [DBITS-1:0]      m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DBITS-1:0]      m1_addr,
  input  logic [DBITS-1:0]      m1_wdata,
  input  logic                  m1_lock,

  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DBITS-1:0]      rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DMEM_WBITS-1:0] mem_addr,
  output logic [DBITS-1:0]      mem_wdata,
  input  logic [DBITS-1:0]      mem_rdata,

  input  logic [3:0]            key_in,
  input  logic [9:0]            sw_in,
  output logic [15:0]           hex_out,
  output logic [9:0]            ledr_out,
  output logic [7:0]            ledg_out,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(MAX_LOCK);

  localparam logic [DBITS-1:0] A_HEX  = DBITS'(ADDR_HEX);
  localparam logic [DBITS-1:0] A_LEDR = DBITS'(ADDR_LEDR);
  localparam logic [DBITS-1:0] A_LEDG = DBITS'(ADDR_LEDG);
  localparam logic [DBITS-1:0] A_KEY  = DBITS'(ADDR_KEY);
  localparam logic [DBITS-1:0] A_SW   = DBITS'(ADDR_SW);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rr_last_q, rr_last_d;   // last granted port (0 or 1)

  logic             gnt0, gnt1, g_valid;
  logic             g_we;
  logic [DBITS-1:0] g_addr, g_wdata;
  sel_e             g_sel;

  logic [3:0]       key_sync;
  logic [9:0]       sw_sync;

  logic [15:0]      hex_q;
  logic [9:0]       ledr_q;
  logic [7:0]       ledg_q;
  logic             bus_err_q;

  logic             rvalid0_q, rvalid1_q;
  logic             rd_mem_q;               // pending read is served by memory
  logic [DBITS-1:0] io_rdata_q, io_rd_val;

  // ---------------------------------------------------------------------------
  // Arbitration and lock FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      UNLOCKED: begin
        if (m0_req && m1_req) begin
          // Both requesting: the port that did not win last time goes.
          gnt0 = rr_last_q;
          gnt1 = !rr_last_q;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
        if (gnt1 && m1_lock) begin
          // The acquiring grant is the first cycle of the burst.
          state_d    = LOCKED;
          lock_cnt_d = CNT_W'(1);
        end
      end
      LOCKED: begin
        gnt1       = m1_req;
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (!m1_lock) begin
          state_d    = UNLOCKED;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_W'(MAX_LOCK - 1)) begin
          state_d    = COOLDOWN;
          lock_cnt_d = '0;
        end
      end
      COOLDOWN: begin
        gnt0    = m0_req;
        gnt1    = m1_req && !m0_req;
        state_d = UNLOCKED;
      end
      default: begin
        state_d    = UNLOCKED;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (gnt1)      rr_last_d = 1'b1;
    else if (gnt0) rr_last_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      rr_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // ---------------------------------------------------------------------------
  // Granted request and address decode
  // ---------------------------------------------------------------------------
  assign g_valid = gnt0 || gnt1;
  assign g_we    = gnt1 ? m1_we    : m0_we;
  assign g_addr  = gnt1 ? m1_addr  : m0_addr;
  assign g_wdata = gnt1 ? m1_wdata : m0_wdata;

  always_comb begin
    g_sel = SEL_NONE;
    if (g_addr[DBITS-1:DMEM_WBITS+2] == '0)          g_sel = SEL_MEM;
    else if (g_addr[DBITS-1:2] == A_HEX[DBITS-1:2])  g_sel = SEL_HEX;
    else if (g_addr[DBITS-1:2] == A_LEDR[DBITS-1:2]) g_sel = SEL_LEDR;
    else if (g_addr[DBITS-1:2] == A_LEDG[DBITS-1:2]) g_sel = SEL_LEDG;
    else if (g_addr[DBITS-1:2] == A_KEY[DBITS-1:2])  g_sel = SEL_KEY;
    else if (g_addr[DBITS-1:2] == A_SW[DBITS-1:2])   g_sel = SEL_SW;
  end

  // Byte-lane bits do not take part in any decode.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^g_addr[1:0];

  assign mem_en    = g_valid && (g_sel == SEL_MEM);
  assign mem_we    = mem_en && g_we;
  assign mem_addr  = g_addr[DMEM_WBITS+1:2];
  assign mem_wdata = g_wdata;

  // ---------------------------------------------------------------------------
  // I/O registers and input synchronisers
  // ---------------------------------------------------------------------------
  io_sync2 #(.WIDTH(4)) u_key_sync (
    .clk  (clk),
    .rst_n(reset),
    .d_i  (key_in),
    .q_o  (key_sync)
  );

  io_sync2 #(.WIDTH(10)) u_sw_sync (
    .clk  (clk),
    .rst_n(reset),
    .d_i  (sw_in),
    .q_o  (sw_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q     <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      bus_err_q <= 1'b0;
    end else if (g_valid) begin
      if (g_we) begin
        // KEY/SW are read-only; unmapped writes are dropped.
        case (g_sel)
          SEL_HEX:  hex_q  <= g_wdata[15:0];
          SEL_LEDR: ledr_q <= g_wdata[9:0];
          SEL_LEDG: ledg_q <= g_wdata[7:0];
          default:  ;
        endcase
      end
      if (g_sel == SEL_NONE) bus_err_q <= 1'b1;
    end
  end

  assign hex_out  = hex_q;
  assign ledr_out = ledr_q;
  assign ledg_out = ledg_q;
  assign bus_err  = bus_err_q;

  // ---------------------------------------------------------------------------
  // Read return: memory data arrives one cycle after mem_en; register reads
  // are captured at the grant edge so both paths share the same latency.
  // ---------------------------------------------------------------------------
  always_comb begin
    io_rd_val = '0;
    case (g_sel)
      SEL_HEX:  io_rd_val = DBITS'(hex_q);
      SEL_LEDR: io_rd_val = DBITS'(ledr_q);
      SEL_LEDG: io_rd_val = DBITS'(ledg_q);
      SEL_KEY:  io_rd_val = DBITS'(key_sync);
      SEL_SW:   io_rd_val = DBITS'(sw_sync);
      default:  io_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rd_mem_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      rvalid0_q <= gnt0 && !m0_we;
      rvalid1_q <= gnt1 && !m1_we;
      if (g_valid && !g_we) begin
        rd_mem_q   <= (g_sel == SEL_MEM);
        io_rdata_q <= io_rd_val;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rvalid0_q || rvalid1_q) rdata = rd_mem_q ? mem_rdata : io_rdata_q;
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;

endmodule
